// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle for id_ex_stage: decoded ID inputs, redirect/ready controls,
// and the registered EX-side outputs. The master is the surrounding core; the slave is the stage.
interface id_ex_stage_if #(
  parameter int XLEN     = 64,
  parameter int ALU_OP_W = 4
);
  logic                id_valid;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [4:0]          id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_imm;
  logic [XLEN-1:0]     id_pc;
  logic                flush_ex;
  logic                ex_ready;

  logic                stall_id;
  logic                ex_valid;
  logic [4:0]          rs1_ex;
  logic [4:0]          rs2_ex;
  logic [4:0]          rd_ex;
  logic                reg_write_ex;
  logic                mem_read_ex;
  logic                mem_write_ex;
  logic [ALU_OP_W-1:0] alu_op_ex;
  logic [XLEN-1:0]     rs1_data_ex;
  logic [XLEN-1:0]     rs2_data_ex;
  logic [XLEN-1:0]     imm_ex;
  logic [XLEN-1:0]     pc_ex;
  logic [31:0]         bubble_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_alu_op,
           id_rs1_data, id_rs2_data, id_imm, id_pc, flush_ex, ex_ready,
    input  stall_id, ex_valid, rs1_ex, rs2_ex, rd_ex, reg_write_ex,
           mem_read_ex, mem_write_ex, alu_op_ex, rs1_data_ex, rs2_data_ex,
           imm_ex, pc_ex, bubble_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_alu_op,
           id_rs1_data, id_rs2_data, id_imm, id_pc, flush_ex, ex_ready,
    output stall_id, ex_valid, rs1_ex, rs2_ex, rd_ex, reg_write_ex,
           mem_read_ex, mem_write_ex, alu_op_ex, rs1_data_ex, rs2_data_ex,
           imm_ex, pc_ex, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional load-use bubble counter enabled by defining PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN     = 64,
  parameter int ALU_OP_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  id_ex_stage_if.slave bus
);
  logic                ex_valid_q;
  logic [4:0]          rs1_q;
  logic [4:0]          rs2_q;
  logic [4:0]          rd_q;
  logic                reg_write_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic [XLEN-1:0]     rs1_data_q;
  logic [XLEN-1:0]     rs2_data_q;
  logic [XLEN-1:0]     imm_q;
  logic [XLEN-1:0]     pc_q;
  logic                load_use;

  // x0 is excluded so a load targeting x0 never stalls a reader of x0.
  assign load_use = ex_valid_q & mem_read_q & (rd_q != 5'd0) & bus.id_valid &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == rd_q)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == rd_q)));

  assign bus.stall_id = ~bus.flush_ex & (~bus.ex_ready | load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_op_q    <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (bus.flush_ex || (bus.ex_ready && load_use)) begin
      // Flush and bubble both kill the slot; operands and addresses hold.
      ex_valid_q  <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (bus.ex_ready) begin
      ex_valid_q  <= bus.id_valid;
      rs1_q       <= bus.id_rs1;
      rs2_q       <= bus.id_rs2;
      rd_q        <= bus.id_rd;
      reg_write_q <= bus.id_valid & bus.id_reg_write;
      mem_read_q  <= bus.id_valid & bus.id_mem_read;
      mem_write_q <= bus.id_valid & bus.id_mem_write;
      alu_op_q    <= bus.id_alu_op;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      pc_q        <= bus.id_pc;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.rs1_ex       = rs1_q;
  assign bus.rs2_ex       = rs2_q;
  assign bus.rd_ex        = rd_q;
  assign bus.reg_write_ex = reg_write_q;
  assign bus.mem_read_ex  = mem_read_q;
  assign bus.mem_write_ex = mem_write_q;
  assign bus.alu_op_ex    = alu_op_q;
  assign bus.rs1_data_ex  = rs1_data_q;
  assign bus.rs2_data_ex  = rs2_data_q;
  assign bus.imm_ex       = imm_q;
  assign bus.pc_ex        = pc_q;

`ifdef PERF_CNT_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (!bus.flush_ex && bus.ex_ready && load_use && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bus.bubble_count = bubble_q;
`else
  assign bus.bubble_count = 32'd0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed rows push expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(64), .ALU_OP_W(4)) bus ();

  id_ex_stage #(.XLEN(64), .ALU_OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        stall;
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [63:0] d;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Operand fields are derived from one seed so every field is distinct.
  function automatic logic [63:0] f_rs2(input logic [63:0] d); return d * 64'd3; endfunction
  function automatic logic [63:0] f_imm(input logic [63:0] d); return d << 4; endfunction
  function automatic logic [63:0] f_pc(input logic [63:0] d);  return d << 8; endfunction

  task automatic r(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                   input logic u1, input logic u2, input logic [4:0] rd,
                   input logic rw, input logic mr, input logic mw,
                   input logic fl, input logic rdy, input logic [63:0] d, input logic rn,
                   input logic e_stall, input logic e_v, input logic [4:0] e_rs1,
                   input logic [4:0] e_rs2, input logic [4:0] e_rd, input logic e_rw,
                   input logic e_mr, input logic e_mw, input logic [63:0] e_d,
                   input logic [31:0] e_bc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_alu_op    = d[3:0];
    bus.id_rs1_data  = d;
    bus.id_rs2_data  = f_rs2(d);
    bus.id_imm       = f_imm(d);
    bus.id_pc        = f_pc(d);
    bus.flush_ex     = fl;
    bus.ex_ready     = rdy;
    rst_n            = rn;
    e.stall = e_stall; e.v = e_v; e.rs1 = e_rs1; e.rs2 = e_rs2; e.rd = e_rd;
    e.rw = e_rw; e.mr = e_mr; e.mw = e_mw; e.d = e_d;
`ifdef PERF_CNT_EN
    e.bc = e_bc;
`else
    e.bc = 32'd0;
`endif
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_id",     {63'd0, bus.stall_id},     {63'd0, e.stall});
        chk("ex_valid",     {63'd0, bus.ex_valid},     {63'd0, e.v});
        chk("rs1_ex",       {59'd0, bus.rs1_ex},       {59'd0, e.rs1});
        chk("rs2_ex",       {59'd0, bus.rs2_ex},       {59'd0, e.rs2});
        chk("rd_ex",        {59'd0, bus.rd_ex},        {59'd0, e.rd});
        chk("reg_write_ex", {63'd0, bus.reg_write_ex}, {63'd0, e.rw});
        chk("mem_read_ex",  {63'd0, bus.mem_read_ex},  {63'd0, e.mr});
        chk("mem_write_ex", {63'd0, bus.mem_write_ex}, {63'd0, e.mw});
        chk("alu_op_ex",    {60'd0, bus.alu_op_ex},    {60'd0, e.d[3:0]});
        chk("rs1_data_ex",  bus.rs1_data_ex,           e.d);
        chk("rs2_data_ex",  bus.rs2_data_ex,           f_rs2(e.d));
        chk("imm_ex",       bus.imm_ex,                f_imm(e.d));
        chk("pc_ex",        bus.pc_ex,                 f_pc(e.d));
        chk("bubble_count", {32'd0, bus.bubble_count}, {32'd0, e.bc});
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0;
    bus.id_uses_rs2 = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.id_alu_op = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_imm = 0; bus.id_pc = 0; bus.flush_ex = 0; bus.ex_ready = 1;
    //  v rs1 rs2 u1 u2 rd rw mr mw fl rdy d         rn | st v rs1 rs2 rd rw mr mw d         bc
    r(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0,     0,   0, 0, 0,  0,  0, 0, 0, 0, 64'h0,     0); // in reset
    r(1, 1,  2, 1, 1, 5, 1, 0, 0, 0, 1, 64'h1234,  1,   0, 0, 0,  0,  0, 0, 0, 0, 64'h0,     0); // release
    r(1, 2,  0, 1, 0, 7, 1, 1, 0, 0, 1, 64'h2000,  1,   0, 1, 1,  2,  5, 1, 0, 0, 64'h1234,  0); // normal advance seen
    r(1, 1,  7, 1, 1, 8, 1, 0, 0, 0, 1, 64'h3000,  1,   1, 1, 2,  0,  7, 1, 1, 0, 64'h2000,  0); // load-use on rs2
    r(1, 1,  7, 1, 1, 8, 1, 0, 0, 0, 1, 64'h3000,  1,   0, 0, 2,  0,  0, 0, 0, 0, 64'h2000,  1); // bubble
    r(1, 3,  0, 1, 0, 0, 1, 1, 0, 0, 1, 64'h5000,  1,   0, 1, 1,  7,  8, 1, 0, 0, 64'h3000,  1); // add advances
    r(1, 0,  0, 1, 1, 4, 1, 0, 0, 0, 1, 64'h6000,  1,   0, 1, 3,  0,  0, 1, 1, 0, 64'h5000,  1); // load to x0
    r(1, 0,  0, 0, 0, 3, 1, 1, 0, 0, 1, 64'h7000,  1,   0, 1, 0,  0,  4, 1, 0, 0, 64'h6000,  1);
    r(1, 3,  1, 0, 1, 9, 1, 0, 0, 0, 1, 64'h8000,  1,   0, 1, 0,  0,  3, 1, 1, 0, 64'h7000,  1); // rs1 unused
    r(1, 0,  0, 0, 0, 6, 1, 1, 0, 0, 1, 64'h9000,  1,   0, 1, 3,  1,  9, 1, 0, 0, 64'h8000,  1);
    r(1, 0,  6, 1, 1, 0, 0, 0, 1, 1, 0, 64'hA000,  1,   0, 1, 0,  0,  6, 1, 1, 0, 64'h9000,  1); // flush over hazard+busy
    r(1, 0,  0, 0, 0, 6, 1, 1, 0, 0, 1, 64'hB000,  1,   0, 0, 0,  0,  0, 0, 0, 0, 64'h9000,  1); // flushed
    r(1, 0,  6, 1, 1, 0, 0, 0, 1, 0, 1, 64'hA000,  1,   1, 1, 0,  0,  6, 1, 1, 0, 64'hB000,  1); // store rs2 hazard
    r(1, 0,  6, 1, 1, 0, 0, 0, 1, 0, 1, 64'hA000,  1,   0, 0, 0,  0,  0, 0, 0, 0, 64'hB000,  2);
    r(1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0, 64'hC000, 1,  1, 1, 0,  6,  0, 0, 0, 1, 64'hA000,  2); // EX busy x3
    r(1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0, 64'hC000, 1,  1, 1, 0,  6,  0, 0, 0, 1, 64'hA000,  2);
    r(1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0, 64'hC000, 1,  1, 1, 0,  6,  0, 0, 0, 1, 64'hA000,  2);
    r(1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 1, 64'hC000, 1,  0, 1, 0,  6,  0, 0, 0, 1, 64'hA000,  2); // release
    r(0, 1,  2, 1, 1, 13, 1, 1, 1, 0, 1, 64'hD000, 1,   0, 1, 10, 11, 12, 1, 0, 0, 64'hC000, 2); // invalid ID
    r(1, 5,  5, 1, 1, 14, 1, 0, 0, 0, 1, 64'hE001, 1,   0, 0, 1,  2,  13, 0, 0, 0, 64'hD000, 2); // gated controls
    r(1, 0,  0, 0, 0, 15, 1, 0, 0, 0, 1, 64'hF002, 1,   0, 1, 5,  5,  14, 1, 0, 0, 64'hE001, 2);
    r(1, 0,  0, 0, 0, 16, 1, 0, 0, 0, 1, 64'h10003, 1,  0, 1, 0,  0,  15, 1, 0, 0, 64'hF002, 2);
    r(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0,     0,   0, 0, 0,  0,  0, 0, 0, 0, 64'h0,     0); // async reset
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RV64I core, with load-use hazard detection and bubble insertion. Captures decoded operands and control from ID and drives the EX-stage register addresses and controls. Those outputs feed the forwarding unit (rs1_ex, rs2_ex) and the EX datapath. Generates the upstream stall that freezes PC and IF/ID when a load result cannot be forwarded in time.

Parameters:
XLEN, 64, datapath width (operands, immediate, PC)
ALU_OP_W, 4, width of ALU operation encoding

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_rs1  input  5  source register 1 address
id_rs2  input  5  source register 2 address
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_rd  input  5  destination register address
id_reg_write  input  1  writes rd
id_mem_read  input  1  is a load
id_mem_write  input  1  is a store
id_alu_op  input  ALU_OP_W  ALU operation
id_rs1_data  input  XLEN  register-file read data 1
id_rs2_data  input  XLEN  register-file read data 2
id_imm  input  XLEN  sign-extended immediate
id_pc  input  XLEN  instruction PC
flush_ex  input  1  branch/jump redirect resolved in EX; kill ID/EX contents
ex_ready  input  1  EX can accept (low = multicycle EX busy)
stall_id  output  1  hold PC and IF/ID this cycle
ex_valid  output  1  EX holds a real instruction
rs1_ex, rs2_ex  output  5 each  registered source addresses
rd_ex  output  5  registered destination
reg_write_ex, mem_read_ex, mem_write_ex  output  1 each  registered controls
alu_op_ex  output  ALU_OP_W  registered ALU op
rs1_data_ex, rs2_data_ex, imm_ex, pc_ex  output  XLEN each  registered data
bubble_count  output  32  load-use bubble counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): ex_valid, reg_write_ex, mem_read_ex, mem_write_ex = 0. All address, data and alu_op registers = 0. stall_id = 0. bubble_count = 0.
- Latency: 1 cycle, ID to EX outputs, on a normal advance.
- load_use (combinational) = ex_valid & mem_read_ex & (rd_ex != 0) & id_valid & ((id_uses_rs1 & id_rs1 == rd_ex) | (id_uses_rs2 & id_rs2 == rd_ex)).
- Per-edge priority, highest first:
  1. flush_ex=1: ex_valid and all controls cleared, rd_ex=0. The flush wins regardless of ex_ready. stall_id=0 this cycle; upstream is also being redirected.
  2. ex_ready=0: all registers hold. stall_id=1.
  3. load_use=1: insert bubble. ex_valid=0, controls=0, rd_ex=0, data registers hold. stall_id=1. The load advances to MEM, so load_use drops next cycle and the ID instruction then advances; the forwarding unit supplies the result via MEM/WB.
  4. Otherwise: capture all ID inputs. ex_valid=id_valid. Controls are gated by id_valid (invalid ID gives zero controls). stall_id=0.
- stall_id = ~flush_ex & (~ex_ready | load_use). It is purely combinational from registered state plus ID inputs, so the same-cycle ID loop has no additional logic depth.
- Controls are never asserted while ex_valid=0. This invariant must hold after every transition.
- Stores: a store whose rs2 is the load rd still stalls 1 cycle. No MEM-to-MEM bypass.
- x0 is never a hazard source.
- Reset deassertion mid-stream: the first edge after release behaves as case 4 with the current ID inputs.

Optional Feature:
Macro PERF_CNT_EN.
- Defined: bubble_count increments by 1 on every edge where case 3 fires, and saturates at 32'hFFFF_FFFF. It holds otherwise, including under flush and ex_ready=0.
- Undefined: no counter register is built and bubble_count is tied to 0. The port list is identical in both builds.

Test Plan:
- Normal advance: id_valid=1, rd=5, reg_write=1, rs1_data=64'h1234, no hazards -> next cycle ex_valid=1, rd_ex=5, rs1_data_ex=64'h1234, stall_id=0.
- Load-use: EX holds load rd_ex=7. ID has add with rs2=7, uses_rs2=1 -> stall_id=1 that cycle. Next cycle ex_valid=0, reg_write_ex=0, stall_id=0. Cycle after, the add appears with rs2_ex=7. bubble_count=1 when PERF_CNT_EN is defined.
- x0 and unused-operand cases: load rd_ex=0 with ID rs1=0 -> no stall. Load rd_ex=3 with ID rs1=3 but uses_rs1=0 -> no stall.
- Flush over hazard: load_use=1 and ex_ready=0 and flush_ex=1 in the same cycle -> stall_id=0; next cycle ex_valid=0, all controls 0. bubble_count unchanged.
- EX busy: ex_ready=0 for 3 cycles -> all EX outputs unchanged and stall_id=1 each cycle. On release with no hazard, the ID instruction is captured the next edge.
- Async reset: rst_n low mid-cycle with ex_valid=1 -> all outputs 0 immediately, without waiting for clk.
